// File: rtl/qaddsub_pipe.sv
// qaddsub_pipe: two-stage pipelined, multi-lane sign-magnitude fixed-point
// adder/subtractor with valid/ready handshake, canonical zero, per-lane
// overflow flags and a saturating overflow event counter.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_valid / o_ready  input handshake (o_ready is combinational from i_ready)
//   i_sub              1: a-b, 0: a+b (applies to all lanes)
//   i_a, i_b           LANES x N-bit operands, lane k at [k*N +: N]
//   o_valid / i_ready  output handshake
//   o_c                LANES x N-bit results
//   o_ovf              per-lane overflow flags, qualified by o_valid
//   i_cnt_clr          synchronous clear of o_ovf_cnt (wins over increment)
//   o_ovf_cnt          accepted results with any lane overflowed, saturating
//
// Build option: define QADDSUB_PIPE_SAT_EN to saturate overflowed magnitudes
// to all-ones instead of wrapping.
module qaddsub_pipe #(
  parameter int unsigned Q     = 19,
  parameter int unsigned N     = 32,
  parameter int unsigned LANES = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_sub,
  input  logic [LANES*N-1:0]   i_a,
  input  logic [LANES*N-1:0]   i_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [LANES*N-1:0]   o_c,
  output logic [LANES-1:0]     o_ovf,
  input  logic                 i_cnt_clr,
  output logic [CNT_W-1:0]     o_ovf_cnt
);

  localparam int unsigned M = N - 1;  // magnitude width

  // Q only documents the fixed-point format; reject nonsensical settings.
  if (Q >= N) begin : g_bad_q
    $error("qaddsub_pipe: Q must be smaller than N");
  end

  // Stage 1: effective signs, magnitudes, magnitude compare
  logic                 s1_valid_q;
  logic [LANES-1:0]     s1_sa_q, s1_sa_d;
  logic [LANES-1:0]     s1_sb_q, s1_sb_d;
  logic [LANES-1:0]     s1_ge_q, s1_ge_d;
  logic [LANES*M-1:0]   s1_ma_q, s1_ma_d;
  logic [LANES*M-1:0]   s1_mb_q, s1_mb_d;

  // Stage 2: results
  logic                 s2_valid_q;
  logic [LANES*N-1:0]   c_q, c_d;
  logic [LANES-1:0]     ovf_q, ovf_d;

  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic s1_adv, s2_adv;

  assign s2_adv  = !s2_valid_q || i_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign o_ready = s1_adv;
  assign o_valid = s2_valid_q;
  assign o_c     = c_q;
  assign o_ovf   = ovf_q;
  assign o_ovf_cnt = cnt_q;

  always_comb begin
    s1_sa_d = '0;
    s1_sb_d = '0;
    s1_ge_d = '0;
    s1_ma_d = '0;
    s1_mb_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      s1_sa_d[k]          = i_a[k*N + M];
      s1_sb_d[k]          = i_b[k*N + M] ^ i_sub;
      s1_ma_d[k*M +: M]   = i_a[k*N +: M];
      s1_mb_d[k*M +: M]   = i_b[k*N +: M];
      s1_ge_d[k]          = i_a[k*N +: M] >= i_b[k*N +: M];
    end
  end

  always_comb begin
    logic [N-1:0] sum;
    logic [M-1:0] mag;
    logic         sgn;
    logic         ov;
    c_d   = '0;
    ovf_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum = {1'b0, s1_ma_q[k*M +: M]} + {1'b0, s1_mb_q[k*M +: M]};
      mag = '0;
      sgn = 1'b0;
      ov  = 1'b0;
      if (s1_sa_q[k] == s1_sb_q[k]) begin
        mag = sum[M-1:0];
        ov  = sum[M];
        sgn = s1_sa_q[k];
      end else if (s1_ge_q[k]) begin
        // equal magnitudes land here, so a's sign is kept (zero fixed below)
        mag = s1_ma_q[k*M +: M] - s1_mb_q[k*M +: M];
        sgn = s1_sa_q[k];
      end else begin
        mag = s1_mb_q[k*M +: M] - s1_ma_q[k*M +: M];
        sgn = s1_sb_q[k];
      end
`ifdef QADDSUB_PIPE_SAT_EN
      if (ov) begin
        mag = '1;
      end
`endif
      if (mag == '0) begin
        sgn = 1'b0;
      end
      c_d[k*N +: N] = {sgn, mag};
      ovf_d[k]      = ov;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && i_ready && (|ovf_q) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sa_q    <= '0;
      s1_sb_q    <= '0;
      s1_ge_q    <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
      s2_valid_q <= 1'b0;
      c_q        <= '0;
      ovf_q      <= '0;
      cnt_q      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= i_valid;
        if (i_valid) begin
          s1_sa_q <= s1_sa_d;
          s1_sb_q <= s1_sb_d;
          s1_ge_q <= s1_ge_d;
          s1_ma_q <= s1_ma_d;
          s1_mb_q <= s1_mb_d;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          c_q   <= c_d;
          ovf_q <= ovf_d;
        end
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_qaddsub_pipe.sv
// Testbench for qaddsub_pipe: single-lane instance driven by directed and
// randomized traffic against a signed-integer reference model, plus a
// four-lane instance checked lane by lane.
module tb_qaddsub_pipe;

  localparam int unsigned N = 32;

`ifdef QADDSUB_PIPE_SAT_EN
  localparam logic [31:0] OVF_C = 32'h7FFFFFFF;
`else
  localparam logic [31:0] OVF_C = 32'h00000000;
`endif

  logic        clk;
  logic        rst_n;
  logic        i_valid, i_sub, i_ready, i_cnt_clr;
  logic [31:0] a, b;
  logic        o_ready, o_valid;
  logic [31:0] o_c;
  logic [0:0]  o_ovf;
  logic [7:0]  o_ovf_cnt;

  logic         v4, sub4;
  logic [127:0] a4, b4;
  logic         o_ready4, o_valid4;
  logic [127:0] o_c4;
  logic [3:0]   o_ovf4;
  logic [7:0]   o_ovf_cnt4;

  qaddsub_pipe #(.Q(19), .N(32), .LANES(1), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sub(i_sub), .i_a(a), .i_b(b), .o_valid(o_valid), .i_ready(i_ready),
    .o_c(o_c), .o_ovf(o_ovf), .i_cnt_clr(i_cnt_clr), .o_ovf_cnt(o_ovf_cnt)
  );

  qaddsub_pipe #(.Q(19), .N(32), .LANES(4), .CNT_W(8)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v4), .o_ready(o_ready4),
    .i_sub(sub4), .i_a(a4), .i_b(b4), .o_valid(o_valid4), .i_ready(1'b1),
    .o_c(o_c4), .o_ovf(o_ovf4), .i_cnt_clr(1'b0), .o_ovf_cnt(o_ovf_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: treat operands as signed integers, add, then re-encode.
  // Returns {ovf, sign, magnitude[30:0]}.
  function automatic logic [32:0] ref_addsub(input logic [31:0] ra, input logic [31:0] rb,
                                             input logic rsub);
    longint va, vb, r, m;
    logic   ovf, sgn;
    logic [30:0] mag;
    va = ra[30:0];
    vb = rb[30:0];
    if (ra[31]) va = -va;
    if (rb[31]) vb = -vb;
    if (rsub) vb = -vb;
    r   = va + vb;
    sgn = (r < 0);
    m   = sgn ? -r : r;
    ovf = (m > 64'sh7FFFFFFF);
`ifdef QADDSUB_PIPE_SAT_EN
    mag = ovf ? 31'h7FFFFFFF : m[30:0];
`else
    mag = m[30:0];
`endif
    if (mag == 31'd0) sgn = 1'b0;
    return {ovf, sgn, mag};
  endfunction

  // Scoreboard for the single-lane instance
  typedef struct packed {logic [31:0] c; logic ovf;} exp_t;
  exp_t        exp_q[$];
  exp_t        e;
  logic [32:0] r;
  logic [7:0]  cnt_m = 8'd0;
  int unsigned n_out = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("ovf_cnt", o_ovf_cnt, cnt_m);
      e = '0;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", o_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_eq("c", o_c, e.c);
          check_eq("ovf", o_ovf, e.ovf);
        end
        n_out++;
      end
      if (i_cnt_clr) cnt_m = 8'd0;
      else if (e.ovf && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
      if (i_valid && o_ready) begin
        r = ref_addsub(a, b, i_sub);
        exp_q.push_back('{c: r[31:0], ovf: r[32]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic ts);
    int guard;
    guard   = 0;
    i_valid = 1'b1;
    a       = ta;
    b       = tb_;
    i_sub   = ts;
    do begin
      @(negedge clk);
      guard++;
    end while (!o_ready && guard < 50);
    check_eq("send_ready", o_ready, 1'b1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic ts, input logic [31:0] ec, input logic eovf);
    send(ta, tb_, ts);
    @(negedge clk);
    check_eq({tag, "_lat1"}, o_valid, 1'b0);
    @(negedge clk);
    check_eq({tag, "_lat2"}, o_valid, 1'b1);
    check_eq({tag, "_c"}, o_c, ec);
    check_eq({tag, "_ovf"}, o_ovf, eovf);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard   = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_eq(tag, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: v = 32'h7FFFFFFF;
      1: v = 32'h80000000;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h00000000;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] hold;
  logic        acc;
  int unsigned idx, n0, guard;
  logic [127:0] exp4;
  logic [3:0]   expovf4;
  logic [31:0]  la, lb;
  logic [32:0]  lr;

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_sub = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
    a = '0; b = '0; v4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_c", o_c, 32'h0);
    check_eq("rst_ovf", o_ovf, 1'b0);
    check_eq("rst_cnt", o_ovf_cnt, 8'h0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_ready", o_ready, 1'b1);
    @(posedge clk); #1;

    directed("add15_225", 32'h000C0000, 32'h00120000, 1'b0, 32'h001E0000, 1'b0);
    directed("mixed",     32'h00080000, 32'h80180000, 1'b0, 32'h80100000, 1'b0);
    directed("sub_eq",    32'h00100000, 32'h00100000, 1'b1, 32'h00000000, 1'b0);
    directed("negzero",   32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0);
    directed("ovf1",      32'h7FFFFFFF, 32'h00000001, 1'b0, OVF_C,        1'b1);
    check_eq("cnt_0to1", o_ovf_cnt, 8'h01);

    for (int i = 0; i < 300; i++) send(32'h7FFFFFFF, 32'h00000001, 1'b0);
    drain("drain_ovf");
    check_eq("cnt_sat", o_ovf_cnt, 8'hFF);

    // clear coincident with an overflowed output transfer
    send(32'h7FFFFFFF, 32'h00000001, 1'b0);
    @(posedge clk); #1;
    check_eq("clr_ovalid", o_valid, 1'b1);
    i_cnt_clr = 1'b1;
    @(posedge clk); #1;
    i_cnt_clr = 1'b0;
    check_eq("cnt_clr", o_ovf_cnt, 8'h00);

    // backpressure
    i_ready = 1'b0;
    idx = 0;
    hold = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      i_valid = 1'b1;
      a = (idx + 1) << 16;
      b = 32'h80000000 | (idx << 12);
      i_sub = idx[0];
      @(negedge clk);
      if (o_ready) idx++;
      if (cyc == 3) hold = o_c;
      if (cyc > 3) check_eq("bp_hold", o_c, hold);
      @(posedge clk); #1;
    end
    check_eq("bp_accepted", idx, 2);
    check_eq("bp_ready", o_ready, 1'b0);
    n0 = n_out;
    i_ready = 1'b1;
    guard = 0;
    while (idx < 4 && guard < 20) begin
      a = (idx + 1) << 16;
      b = 32'h80000000 | (idx << 12);
      i_sub = idx[0];
      @(negedge clk);
      if (o_ready) idx++;
      guard++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    drain("drain_bp");
    check_eq("bp_count", n_out - n0, 4);

    // reset with two transactions in flight
    send(32'h00010000, 32'h00020000, 1'b0);
    send(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", o_valid, 1'b0);
    check_eq("midrst_cnt", o_ovf_cnt, 8'h00);
    check_eq("midrst_c", o_c, 32'h0);
    exp_q.delete();
    cnt_m = 8'd0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("midrst_stale", o_valid, 1'b0);
    end
    @(posedge clk); #1;

    // randomized traffic with random backpressure
    acc = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if (acc || !i_valid) begin
        i_valid = ($urandom_range(0, 3) != 0);
        a = pick_operand();
        b = pick_operand();
        if ($urandom_range(0, 5) == 0) b = {$urandom_range(0, 1) == 1, a[30:0]};
        i_sub = $urandom_range(0, 1) == 1;
      end
      @(negedge clk);
      acc = i_valid && o_ready;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    drain("drain_rand");

    // four-lane instance
    for (int it = 0; it < 10; it++) begin
      sub4 = $urandom_range(0, 1) == 1;
      exp4 = '0;
      expovf4 = '0;
      for (int k = 0; k < 4; k++) begin
        if (it == 0) begin
          la = 32'(k * 5179347);
          lb = 32'h80000000 | 32'(k * 3779351);
        end else begin
          la = pick_operand();
          lb = pick_operand();
        end
        a4[k*N +: N] = la;
        b4[k*N +: N] = lb;
        lr = ref_addsub(la, lb, sub4);
        exp4[k*N +: N] = lr[31:0];
        expovf4[k] = lr[32];
      end
      v4 = 1'b1;
      @(negedge clk);
      check_eq("l4_ready", o_ready4, 1'b1);
      @(posedge clk); #1;
      v4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("l4_valid", o_valid4, 1'b1);
      check_eq("l4_c", o_c4, exp4);
      check_eq("l4_ovf", o_ovf4, expovf4);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qaddsub_pipe.md
Name: qaddsub_pipe

Overview:
- Pipelined, multi-lane, sign-magnitude fixed-point adder/subtractor. Successor to the combinational qadd.
- Adds a per-transaction add/sub mode, valid/ready backpressure, and canonical zero.
- Adds per-lane overflow detection and a saturating overflow event counter.
- Sits between the fixed-point operand sources and the metaball field accumulation datapath.

Parameters:
- Q, 19, number of fractional bits (used for documentation and bench scaling only; the arithmetic is format-agnostic).
- N, 32, word width: bit N-1 is the sign, bits N-2:0 are the magnitude.
- LANES, 1, independent lanes sharing one handshake. Data buses are LANES*N wide, lane k at bits [k*N +: N].
- CNT_W, 8, width of the overflow event counter.

Ports:
- i_clk, in, 1, clock; all state changes on the rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_valid, in, 1, input operands valid.
- o_ready, out, 1, block can accept input this cycle.
- i_sub, in, 1, 1 = compute a-b (b's sign inverted), 0 = compute a+b.
- i_a, in, LANES*N, operand a per lane.
- i_b, in, LANES*N, operand b per lane.
- o_valid, out, 1, result valid.
- i_ready, in, 1, downstream accepts the result.
- o_c, out, LANES*N, result per lane.
- o_ovf, out, LANES, per-lane overflow flag, qualified by o_valid.
- i_cnt_clr, in, 1, synchronous clear of the overflow counter.
- o_ovf_cnt, out, CNT_W, count of accepted results with any lane overflowed; saturates at all-ones.

Behaviour:
- Reset:
  - Asserting i_rst_n low clears both stage valid bits, o_c, o_ovf and o_ovf_cnt to 0 immediately, regardless of the clock.
  - o_ready is 1 as soon as reset deasserts.
  - Any in-flight transactions are discarded.
- Pipeline: two register stages S1 and S2. Latency is exactly 2 cycles from an input handshake to o_valid when unstalled. Throughput is 1 per cycle.
- Handshake:
  - Input transfer occurs when i_valid & o_ready.
  - Output transfer occurs when o_valid & i_ready.
  - S2 advances when !S2.valid | i_ready.
  - S1 advances when !S1.valid | S2 advances.
  - o_ready = S1 advances. This is combinational from i_ready, with no input-to-output combinational data path.
  - o_c and o_ovf hold stable while o_valid & !i_ready.
  - Results are never dropped or duplicated, and order is preserved.
- S1 (per lane):
  - Register sa = a[N-1] and sb = b[N-1]^i_sub.
  - Register ma and mb = the magnitudes.
  - Register the compare ma >= mb.
- S2 (per lane):
  - Same effective sign (sa == sb): mag = ma+mb computed N bits wide, ovf = carry into bit N-1, sign = sa.
  - Different signs: mag = larger minus smaller, sign = sign of the larger. When ma == mb, a's sign is used. ovf = 0.
  - Overflow without SAT: magnitude wraps (the carry is dropped).
  - Canonical zero: if the final magnitude is 0, the sign is forced to 0. Negative zero is never output.
  - Negative-zero inputs are accepted and treated as 0.
- Counter:
  - On each output transfer with |o_ovf, o_ovf_cnt increments and holds at 2^CNT_W-1.
  - i_cnt_clr has priority over an increment in the same cycle.

Optional Feature:
- QADDSUB_PIPE_SAT_EN defined: when a lane overflows, its magnitude becomes all-ones (2^(N-1)-1) with the computed sign, and o_ovf is still asserted.
- Not defined: the magnitude wraps as described above, and o_ovf is asserted.
- The counter behaves the same in both builds.

Test Plan (N=32, Q=19, LANES=1 unless stated, i_ready=1 unless stated):
- 1.5+2.25: a=0x000C0000, b=0x00120000, i_sub=0 -> o_c=0x001E0000, o_ovf=0, o_valid exactly 2 cycles after the handshake.
- Mixed signs and subtract:
  - a=0x00080000, b=0x80180000 -> 0x80100000 (-2.0).
  - a=0x00100000, b=0x00100000, i_sub=1 -> 0x00000000 (sign 0).
  - a=0x80000000, b=0x80000000 -> 0x00000000.
- Overflow: a=0x7FFFFFFF, b=0x00000001 -> without SAT o_c=0x00000000, o_ovf=1; with SAT o_c=0x7FFFFFFF, o_ovf=1; o_ovf_cnt increments 0->1. Repeat 300 times with CNT_W=8 -> o_ovf_cnt holds 0xFF. Assert i_cnt_clr together with an overflow -> counter 0.
- Backpressure: drive 4 back-to-back inputs with i_ready=0 -> o_ready drops after 2 accepted. Release i_ready -> all 4 results emerge in order, with o_c stable during the stall.
- Reset mid-flight: 2 transactions in the pipeline, pulse i_rst_n low between clock edges -> o_valid=0 and o_ovf_cnt=0 immediately, no stale result after release.
- LANES=4 sweep: lane k uses a=k*5179347, b=0x80000000|(k*3779351), random i_sub -> each lane matches the reference model and the lanes are independent.
